// File: rtl/note_pkg.sv
// Shared constants and letter codes for the note lookup arbiter.
// Letter encoding: 0 = rest, 1..7 = A..G.
package note_pkg;

   localparam int NOTE_W        = 6;
   localparam int SEMIS_PER_OCT = 12;

   localparam logic [NOTE_W-1:0] REST_NOTE = '0;

   typedef enum logic [5:0] {
      LETTER_REST = 6'd0,
      LETTER_A    = 6'd1,
      LETTER_B    = 6'd2,
      LETTER_C    = 6'd3,
      LETTER_D    = 6'd4,
      LETTER_E    = 6'd5,
      LETTER_F    = 6'd6,
      LETTER_G    = 6'd7
   } letter_e;

endpackage

// File: rtl/note_lookup_arbiter_if.sv
// Request/response bundle between requesters, arbiter and drawing logic.
// Ports: req valid/note/ready per requester, response valid/ready/id/fields, busy.
interface note_lookup_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]   req_valid_in;
   logic [6*NUM_REQ-1:0] req_note_in;
   logic [NUM_REQ-1:0]   req_ready_out;
   logic                 resp_ready_in;
   logic                 resp_valid_out;
   logic [ID_W-1:0]      resp_id_out;
   logic [5:0]           resp_letter_out;
   logic [2:0]           resp_octave_out;
   logic                 resp_sharp_out;
   logic                 busy_out;

   modport master (
      output req_valid_in, req_note_in, resp_ready_in,
      input  req_ready_out, resp_valid_out, resp_id_out,
      input  resp_letter_out, resp_octave_out, resp_sharp_out,
      input  busy_out
   );

   modport slave (
      input  req_valid_in, req_note_in, resp_ready_in,
      output req_ready_out, resp_valid_out, resp_id_out,
      output resp_letter_out, resp_octave_out, resp_sharp_out,
      output busy_out
   );

endinterface

// File: rtl/note_field_decode.sv
// Combinational note index -> {letter, octave, sharp}.
// Ports: note in; letter, octave, sharp out. Note 0 is a rest.
module note_field_decode
   import note_pkg::*;
(
   input  logic [NOTE_W-1:0] note,
   output logic [5:0]        letter,
   output logic [2:0]        octave,
   output logic              sharp
);

   logic [NOTE_W-1:0] m;
   logic [3:0]        k;

   assign m = note - NOTE_W'(1);
   assign k = 4'(m % NOTE_W'(SEMIS_PER_OCT));

   always_comb begin
      letter = LETTER_REST;
      octave = 3'd0;
      sharp  = 1'b0;
      if (note != REST_NOTE) begin
         octave = 3'(m / NOTE_W'(SEMIS_PER_OCT)) + 3'd1;
         // semitone k=0 is A; sharps sit on the black keys
         case (k)
            4'd0:  letter = LETTER_A;
            4'd1:  begin letter = LETTER_A; sharp = 1'b1; end
            4'd2:  letter = LETTER_B;
            4'd3:  letter = LETTER_C;
            4'd4:  begin letter = LETTER_C; sharp = 1'b1; end
            4'd5:  letter = LETTER_D;
            4'd6:  begin letter = LETTER_D; sharp = 1'b1; end
            4'd7:  letter = LETTER_E;
            4'd8:  letter = LETTER_F;
            4'd9:  begin letter = LETTER_F; sharp = 1'b1; end
            4'd10: letter = LETTER_G;
            4'd11: begin letter = LETTER_G; sharp = 1'b1; end
            default: letter = LETTER_REST;
         endcase
      end
   end

endmodule

// File: rtl/note_lookup_arbiter.sv
// Round-robin share of one note decode path among NUM_REQ requesters.
// Ports: clk_in, rst_n_in (sync, active-low), bus (slave side of the bundle).
module note_lookup_arbiter
   import note_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input logic                  clk_in,
   input logic                  rst_n_in,
   note_lookup_arbiter_if.slave bus
);

   localparam int ID_W = $clog2(NUM_REQ);

   logic              s1_valid;
   logic [NOTE_W-1:0] s1_note;
   logic [ID_W-1:0]   s1_id;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   grant;
   logic [ID_W-1:0]   grant_nxt;
   logic              found;
   logic              adv_out;
   logic              adv_s1;
   logic              xfer;
   logic [5:0]        dec_letter;
   logic [2:0]        dec_octave;
   logic              dec_sharp;

   assign adv_out = !bus.resp_valid_out || bus.resp_ready_in;
   assign adv_s1  = !s1_valid || adv_out;

   // first valid requester at or after rr_ptr, wrapping
   always_comb begin
      int idx;
      idx   = 0;
      grant = '0;
      found = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         idx = int'(rr_ptr) + j;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && bus.req_valid_in[idx]) begin
            found = 1'b1;
            grant = ID_W'(idx);
         end
      end
   end

   assign xfer = rst_n_in && adv_s1 && found;

   assign bus.req_ready_out =
      xfer ? (NUM_REQ'(1) << grant) : '0;

   assign grant_nxt =
      (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

   note_field_decode u_dec (
      .note   (s1_note),
      .letter (dec_letter),
      .octave (dec_octave),
      .sharp  (dec_sharp)
   );

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         s1_valid            <= 1'b0;
         s1_note             <= '0;
         s1_id               <= '0;
         rr_ptr              <= '0;
         bus.resp_valid_out  <= 1'b0;
         bus.resp_id_out     <= '0;
         bus.resp_letter_out <= '0;
         bus.resp_octave_out <= '0;
         bus.resp_sharp_out  <= 1'b0;
      end else begin
         if (adv_s1) begin
            s1_valid <= xfer;
            if (xfer) begin
               s1_note <= bus.req_note_in[NOTE_W*int'(grant) +: NOTE_W];
               s1_id   <= grant;
               rr_ptr  <= grant_nxt;
            end
         end
         if (adv_out) begin
            bus.resp_valid_out <= s1_valid;
            if (s1_valid) begin
               bus.resp_id_out     <= s1_id;
               bus.resp_letter_out <= dec_letter;
               bus.resp_octave_out <= dec_octave;
               bus.resp_sharp_out  <= dec_sharp;
            end
         end
      end
   end

   assign bus.busy_out = s1_valid || bus.resp_valid_out;

endmodule

// File: tb/tb_note_lookup_arbiter.sv
// Self-checking bench for note_lookup_arbiter (NUM_REQ = 4).
// Reference model: in-flight queue plus round-robin pointer.
module tb_note_lookup_arbiter;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   note_lookup_arbiter_if #(.NUM_REQ(N)) bus ();

   note_lookup_arbiter #(.NUM_REQ(N)) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (bus.slave)
   );

   typedef struct {
      int id;
      int note;
      int cyc;
   } item_t;

   item_t        q[$];
   int           ptr = 0;
   int           cyc = 0;
   int           tests = 0;
   int           fails = 0;
   int           exp_g;
   int           exp_note;
   logic [N-1:0] exp_rdy;
   logic         exp_rv;
   logic [17:0]  expv;
   logic [17:0]  actv;

   // {letter[5:0], octave[2:0], sharp}
   function automatic logic [9:0] ref_dec(int n);
      int lt[12] = '{1, 1, 2, 3, 3, 4, 4, 5, 6, 6, 7, 7};
      int k;
      int o;
      logic s;
      if (n == 0) return 10'd0;
      k = (n - 1) % 12;
      o = (n - 1) / 12 + 1;
      s = (k == 1) || (k == 4) || (k == 6) || (k == 9) || (k == 11);
      return {6'(lt[k]), 3'(o), s};
   endfunction

   task automatic set_note(int i, int n);
      bus.req_note_in[6*i +: 6] = 6'(n);
   endtask

   // expectations for the current cycle, sampled at the falling edge
   task automatic sample();
      logic acc;
      int idx;
      @(negedge clk);
      exp_rv = (q.size() > 0) && (q[0].cyc < cyc);
      acc = rst_n && ((q.size() < 2) || bus.resp_ready_in);
      exp_g = -1;
      exp_note = 0;
      for (int j = 0; j < N; j++) begin
         idx = (ptr + j) % N;
         if (exp_g < 0 && bus.req_valid_in[idx]) exp_g = idx;
      end
      exp_rdy = '0;
      if (acc && exp_g >= 0) begin
         exp_rdy[exp_g] = 1'b1;
         exp_note = int'(bus.req_note_in[6*exp_g +: 6]);
      end
      expv = {exp_rdy, exp_rv, q.size() > 0, 12'b0};
      actv = {bus.req_ready_out, bus.resp_valid_out,
              bus.busy_out, 12'b0};
      if (exp_rv) begin
         expv[11:0] = {2'(q[0].id), ref_dec(q[0].note)};
         actv[11:0] = {bus.resp_id_out, bus.resp_letter_out,
                       bus.resp_octave_out, bus.resp_sharp_out};
      end
   endtask

   task automatic advance();
      item_t it;
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         q.delete();
         ptr = 0;
      end else begin
         if (exp_rv && bus.resp_ready_in) void'(q.pop_front());
         if (exp_rdy != '0) begin
            it.id = exp_g;
            it.note = exp_note;
            it.cyc = cyc;
            q.push_back(it);
            ptr = (exp_g + 1) % N;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.req_valid_in = '0;
      bus.resp_ready_in = 1'b1;
      repeat (2) begin
         sample();
         advance();
      end
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.req_valid_in = '1;
      bus.req_note_in = '0;
      bus.resp_ready_in = 1'b1;
      sample();
      advance();
      for (int c = 0; c < 3; c++) begin
         sample();
         tests++;
         if (actv !== expv) begin
            fails++;
            $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, actv, expv);
         end
         tests++;
         if ({bus.req_ready_out, bus.resp_valid_out, bus.busy_out}
             !== 6'b0) begin
            fails++;
            $display("FAIL reset_outs got rdy=%b rv=%b busy=%b exp 0",
                     bus.req_ready_out, bus.resp_valid_out, bus.busy_out);
         end
         advance();
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      bus.req_valid_in = 4'b0001;
      set_note(0, 41);
      for (int c = 0; c < 4; c++) begin
         sample();
         tests++;
         if (actv !== expv) begin
            fails++;
            $display("FAIL single cyc=%0d got=%h exp=%h", cyc, actv, expv);
         end
         if (c == 2) begin
            tests++;
            if ({bus.resp_valid_out, bus.resp_id_out, bus.resp_letter_out,
                 bus.resp_octave_out, bus.resp_sharp_out}
                !== {1'b1, 2'd0, 6'd3, 3'd4, 1'b1}) begin
               fails++;
               $display("FAIL single_fields got v=%b id=%0d l=%0d o=%0d s=%b exp 1/0/3/4/1",
                        bus.resp_valid_out, bus.resp_id_out,
                        bus.resp_letter_out, bus.resp_octave_out,
                        bus.resp_sharp_out);
            end
         end
         advance();
         bus.req_valid_in = '0;
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      bus.req_valid_in = '1;
      set_note(0, 0);
      set_note(1, 1);
      set_note(2, 12);
      set_note(3, 63);
      for (int c = 0; c < 14; c++) begin
         sample();
         tests++;
         if (actv !== expv) begin
            fails++;
            $display("FAIL rr cyc=%0d got=%h exp=%h", cyc, actv, expv);
         end
         if (c >= 2) begin
            tests++;
            if (bus.resp_id_out !== 2'((c - 2) % N)) begin
               fails++;
               $display("FAIL rr_id cyc=%0d got=%0d exp=%0d",
                        cyc, bus.resp_id_out, (c - 2) % N);
            end
         end
         advance();
      end
      bus.req_valid_in = '0;
   endtask

   task automatic test_backpressure();
      logic [11:0] snap;
      do_reset();
      bus.req_valid_in = '1;
      for (int i = 0; i < N; i++) set_note(i, $urandom_range(0, 63));
      for (int c = 0; c < 16; c++) begin
         bus.resp_ready_in = !(c >= 4 && c < 9);
         sample();
         tests++;
         if (actv !== expv) begin
            fails++;
            $display("FAIL bp cyc=%0d got=%h exp=%h", cyc, actv, expv);
         end
         if (c == 4)
            snap = {bus.resp_id_out, bus.resp_letter_out,
                    bus.resp_octave_out, bus.resp_sharp_out};
         if (c > 4 && c < 9) begin
            tests++;
            if ({bus.resp_id_out, bus.resp_letter_out, bus.resp_octave_out,
                 bus.resp_sharp_out} !== snap) begin
               fails++;
               $display("FAIL bp_hold cyc=%0d got=%h exp=%h", cyc,
                        {bus.resp_id_out, bus.resp_letter_out,
                         bus.resp_octave_out, bus.resp_sharp_out}, snap);
            end
         end
         advance();
         for (int i = 0; i < N; i++) set_note(i, $urandom_range(0, 63));
      end
      bus.req_valid_in = '0;
      bus.resp_ready_in = 1'b1;
   endtask

   task automatic test_wrap();
      logic [N-1:0] want[3] = '{4'b0100, 4'b1000, 4'b0010};
      do_reset();
      bus.req_valid_in = 4'b0100;
      set_note(1, 5);
      set_note(2, 30);
      set_note(3, 50);
      for (int c = 0; c < 3; c++) begin
         sample();
         tests++;
         if (actv !== expv) begin
            fails++;
            $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, actv, expv);
         end
         tests++;
         if (bus.req_ready_out !== want[c]) begin
            fails++;
            $display("FAIL wrap_grant step=%0d got=%b exp=%b",
                     c, bus.req_ready_out, want[c]);
         end
         advance();
         bus.req_valid_in = 4'b1010;
      end
      bus.req_valid_in = '0;
   endtask

   task automatic test_reset_midop();
      do_reset();
      bus.req_valid_in = '1;
      bus.resp_ready_in = 1'b0;
      for (int i = 0; i < N; i++) set_note(i, 7 * i + 3);
      for (int c = 0; c < 6; c++) begin
         if (c == 3) rst_n = 1'b0;
         if (c == 5) rst_n = 1'b1;
         sample();
         tests++;
         if (actv !== expv) begin
            fails++;
            $display("FAIL midrst cyc=%0d got=%h exp=%h", cyc, actv, expv);
         end
         if (c == 4 || c == 5) begin
            tests++;
            if ({bus.resp_valid_out, bus.busy_out} !== 2'b00) begin
               fails++;
               $display("FAIL midrst_flush got rv=%b busy=%b exp 0/0",
                        bus.resp_valid_out, bus.busy_out);
            end
         end
         if (c == 5) begin
            tests++;
            if (bus.req_ready_out !== 4'b0001) begin
               fails++;
               $display("FAIL midrst_ptr got=%b exp=0001", bus.req_ready_out);
            end
         end
         advance();
      end
      bus.req_valid_in = '0;
      bus.resp_ready_in = 1'b1;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         bus.req_valid_in = N'($urandom);
         for (int i = 0; i < N; i++) set_note(i, $urandom_range(0, 63));
         bus.resp_ready_in = ($urandom_range(0, 3) != 0);
         sample();
         tests++;
         if (actv !== expv) begin
            fails++;
            $display("FAIL rand cyc=%0d got=%h exp=%h", cyc, actv, expv);
         end
         advance();
      end
      bus.req_valid_in = '0;
   endtask

   initial begin
      bus.req_valid_in = '0;
      bus.req_note_in = '0;
      bus.resp_ready_in = 1'b1;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_wrap();
      test_reset_midop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
